// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one next-level memory port between I-cache and D-cache line bursts.
// Optional macro ARB_RR_EN selects round-robin arbitration instead of fixed D-over-I priority.
module l1_mem_arbiter #(
    parameter int bit_size   = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ic_req,
    input  logic [bit_size-1:0] ic_addr,
    output logic [bit_size-1:0] ic_rdata,
    output logic                ic_rvalid,
    output logic                ic_done,
    output logic                ic_stall,
    input  logic                dc_req,
    input  logic                dc_we,
    input  logic [bit_size-1:0] dc_addr,
    input  logic [bit_size-1:0] dc_wdata,
    output logic [bit_size-1:0] dc_rdata,
    output logic                dc_rvalid,
    output logic                dc_done,
    output logic                dc_stall,
    output logic [IDX_W-1:0]    word_idx,
    output logic                mem_req,
    output logic                mem_we,
    output logic [bit_size-1:0] mem_addr,
    output logic [bit_size-1:0] mem_wdata,
    input  logic [bit_size-1:0] mem_rdata,
    input  logic                mem_ack
);
    typedef enum logic [1:0] {IDLE, BURST_I, BURST_D, DONE} state_t;

    localparam logic [bit_size-1:0] OFF_MASK = bit_size'(LINE_WORDS*4-1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(LINE_WORDS-1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [bit_size-1:0] base_q, base_d;
    logic                we_q, we_d;
    logic                own_q, own_d;
    logic                pick_d;
    logic                in_burst;

`ifdef ARB_RR_EN
    logic last_q, last_d;
    assign pick_d = dc_req & (~ic_req | ~last_q);
`else
    assign pick_d = dc_req;
`endif

    // next-state: grant in IDLE, count acked beats, one DONE cycle per burst
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        we_d    = we_q;
        own_d   = own_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: if (ic_req | dc_req) begin
                state_d = pick_d ? BURST_D : BURST_I;
                own_d   = pick_d;
                base_d  = (pick_d ? dc_addr : ic_addr) & ~OFF_MASK;
                we_d    = pick_d & dc_we;
                idx_d   = '0;
`ifdef ARB_RR_EN
                last_d  = pick_d;
`endif
            end
            BURST_I, BURST_D: if (mem_ack) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == LAST_IDX) ? DONE : state_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset abandons any partial burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            own_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            we_q    <= we_d;
            own_q   <= own_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign in_burst  = (state_q == BURST_I) | (state_q == BURST_D);
    assign word_idx  = idx_q;
    assign mem_req   = in_burst;
    assign mem_we    = (state_q == BURST_D) & we_q;
    assign mem_addr  = in_burst ? base_q + bit_size'({idx_q, 2'b00}) : '0;
    assign mem_wdata = mem_we ? dc_wdata : '0;
    assign ic_rvalid = (state_q == BURST_I) & mem_ack;
    assign dc_rvalid = (state_q == BURST_D) & mem_ack;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = (dc_rvalid & ~we_q) ? mem_rdata : '0;
    assign ic_done   = (state_q == DONE) & ~own_q;
    assign dc_done   = (state_q == DONE) & own_q;
    assign ic_stall  = rst & ic_req & ~ic_done;
    assign dc_stall  = rst & dc_req & ~dc_done;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: scoreboard bench for l1_mem_arbiter (honours ARB_RR_EN when defined).
module tb_l1_mem_arbiter;
    localparam int W  = 32;
    localparam int LW = 4;
    localparam int IW = 2;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0, rst = 1'b0;
    logic          ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ack = 1'b0;
    logic [W-1:0]  ic_addr = '0, dc_addr = '0, mem_rdata = '0, wb_base = '0;
    logic [W-1:0]  dc_wdata, ic_rdata, dc_rdata, mem_addr, mem_wdata;
    logic          ic_rvalid, ic_done, ic_stall, dc_rvalid, dc_done, dc_stall, mem_req, mem_we;
    logic [IW-1:0] word_idx;

    always #5 clk = ~clk;

    // D-cache model: write-back word depends on the beat index the arbiter presents
    assign dc_wdata = wb_base + W'(word_idx);

    l1_mem_arbiter #(.bit_size(W), .LINE_WORDS(LW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
        .ic_done(ic_done), .ic_stall(ic_stall),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done), .dc_stall(dc_stall),
        .word_idx(word_idx), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        bit          d;
        bit          we;
        logic [W-1:0] addr;
        logic [W-1:0] wd;
        int          idx;
    } beat_t;

    beat_t bq[$];
    bit    dq[$];
    int    n_cmp = 0, n_bad = 0;
    int    cyc = 0, ack_mode = 0, acnt = 0, beats = 0, start_cyc = 0;
    int    done_cyc[2];
    bit    last_d = 1'b0, mreq_prev = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference: a line is LW words; beats walk the line from its first word
    task automatic push_burst(input bit d, input bit we, input logic [W-1:0] a, input logic [W-1:0] wb);
        logic [W-1:0] base;
        base = (a / (LW*4)) * (LW*4);
        for (int k = 0; k < LW; k++)
            bq.push_back('{d, we & d, base + W'(4*k), wb + W'(k), k});
        dq.push_back(d);
        last_d = d;
    endtask

    // reference arbitration when both sides request together
    function automatic bit d_first();
        return RR ? !last_d : 1'b1;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // requester: raise req, optionally scramble the address after grant, drop req at the DONE edge
    task automatic run(input bit d, input logic [W-1:0] a, input bit we, input bit scr);
        int t;
        if (d) begin dc_addr = a; dc_we = we; dc_req = 1'b1; end
        else begin ic_addr = a; ic_req = 1'b1; end
        if (scr) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!mem_req && t < 50);
            if (d) dc_addr = $urandom; else ic_addr = $urandom;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!(d ? dc_done : ic_done) && t < 300);
        if (!(d ? dc_done : ic_done)) chk(d ? "dc_done_timeout" : "ic_done_timeout", 0, 1);
        sync();
        if (d) dc_req = 1'b0; else ic_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_word_idx"}, W'(word_idx), 0);
        chk({tag, "_rvalids"}, {ic_rvalid, dc_rvalid}, 0);
        chk({tag, "_dones"}, {ic_done, dc_done}, 0);
        chk({tag, "_stalls"}, {ic_stall, dc_stall}, 0);
        chk({tag, "_rdata"}, ic_rdata | dc_rdata, 0);
    endtask

    always @(posedge clk) cyc++;

    // memory model: ack policy per test, fresh read data every cycle
    initial forever begin
        @(posedge clk);
        #1;
        acnt++;
        mem_ack   = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? (acnt % 3 == 0) : ($urandom_range(0, 2) != 0);
        mem_rdata = $urandom;
    end

    // monitor: compares every beat, done pulse and stall flag against the scoreboard
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            bq.delete();
            dq.delete();
            beats = 0;
            mreq_prev = 1'b0;
        end else begin
            if (mem_req && !mreq_prev) start_cyc = cyc;
            mreq_prev = mem_req;
            if (mem_req) begin
                if (bq.size() == 0) chk("unexpected_mem_req", 1, 0);
                else begin
                    e = bq[0];
                    chk("mem_addr", mem_addr, e.addr);
                    chk("mem_we", mem_we, e.we);
                    chk("word_idx", W'(word_idx), e.idx);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wd);
                    if (mem_ack) begin
                        chk("rvalid_owner", {ic_rvalid, dc_rvalid}, e.d ? 2'b01 : 2'b10);
                        if (!e.we) chk("rdata", e.d ? dc_rdata : ic_rdata, mem_rdata);
                        void'(bq.pop_front());
                        beats++;
                    end else chk("rvalid_no_ack", {ic_rvalid, dc_rvalid}, 0);
                end
            end else chk("rvalid_idle", {ic_rvalid, dc_rvalid}, 0);
            if (ic_done || dc_done) begin
                if (dq.size() == 0) chk("unexpected_done", {ic_done, dc_done}, 0);
                else begin
                    chk("done_side", {ic_done, dc_done}, dq.pop_front() ? 2'b01 : 2'b10);
                    chk("beats_per_line", beats, LW);
                    done_cyc[dc_done ? 1 : 0] = cyc;
                end
                beats = 0;
            end
            chk("ic_stall", ic_stall, ic_req && !ic_done);
            chk("dc_stall", dc_stall, dc_req && !dc_done);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, sc;
        logic [W-1:0] ia, da;
        bit we;
        // reset: everything quiet even with requests pending
        ic_req = 1'b1; dc_req = 1'b1;
        #12;
        check_zero("reset");
        ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // 1: I-only fill, zero-wait, latency check
        ack_mode = 0;
        sync();
        c0 = cyc;
        push_burst(0, 0, 32'h104, 0);
        run(0, 32'h104, 0, 0);
        chk("t1_latency", done_cyc[0] - c0, LW + 1);

        // 2: simultaneous requests, D first then I two cycles after dc_done
        if (d_first()) begin push_burst(1, 0, 32'h200, 0); push_burst(0, 0, 32'h300, 0); end
        else begin push_burst(0, 0, 32'h300, 0); push_burst(1, 0, 32'h200, 0); end
        fork
            run(0, 32'h300, 0, 0);
            run(1, 32'h200, 0, 0);
        join
        chk("t2_gap", start_cyc - done_cyc[1], 2);

        // 3: D write-back
        wb_base = 32'hA0;
        push_burst(1, 1, 32'h3F8, wb_base);
        run(1, 32'h3F8, 1, 0);

        // 4: wait states, ack every third cycle
        ack_mode = 1;
        push_burst(0, 0, 32'h040, 0);
        run(0, 32'h040, 0, 1);

        // 5: reset after two beats of a D fill, then restart from beat 0
        ack_mode = 0;
        push_burst(1, 0, 32'h500, 0);
        fork
            run(1, 32'h500, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                rst = 1'b0;
                #1;
                check_zero("midreset");
                @(negedge clk);
                #1;
                last_d = 1'b0;
                push_burst(1, 0, 32'h500, 0);
                rst = 1'b1;
            end
        join

        // 6: both requesting continuously for three bursts
        dc_addr = 32'h600; ic_addr = 32'h700; dc_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (d_first()) push_burst(1, 0, 32'h600, 0); else push_burst(0, 0, 32'h700, 0);
        end
        ic_req = 1'b1; dc_req = 1'b1;
        n = 0;
        for (int t = 0; t < 500 && n < 3; t++) begin
            @(negedge clk);
            if (ic_done || dc_done) n++;
        end
        chk("t6_bursts", n, 3);
        sync();
        ic_req = 1'b0; dc_req = 1'b0;
        sync();

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            sc = $urandom_range(0, 3);
            ack_mode = $urandom_range(0, 2);
            ia = $urandom; da = $urandom; we = $urandom_range(0, 1);
            wb_base = $urandom;
            case (sc)
                0: begin push_burst(0, 0, ia, 0); run(0, ia, 0, 1); end
                1, 2: begin push_burst(1, sc == 2, da, wb_base); run(1, da, sc == 2, 1); end
                default: begin
                    if (d_first()) begin push_burst(1, we, da, wb_base); push_burst(0, 0, ia, 0); end
                    else begin push_burst(0, 0, ia, 0); push_burst(1, we, da, wb_base); end
                    fork
                        run(0, ia, 0, 0);
                        run(1, da, we, 0);
                    join
                end
            endcase
        end

        repeat (3) @(negedge clk);
        chk("beats_left", bq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
